// File: rtl/mb8_arb_pkg.sv
// rtl/mb8_arb_pkg.sv - shared widths, FSM state and command types for the mb8 RAM arbiter
package mb8_pkg;

    localparam int ASZ = 17;
    localparam int DSZ = 8;
    localparam int CSZ = 2 * DSZ;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        B0   = 2'd1,
        B1   = 2'd2,
        ACK  = 2'd3
    } arb_st_t;

    typedef struct packed {
        logic           we;
        logic           ws;
        logic [ASZ-1:0] ad;
        logic [CSZ-1:0] wd;
    } mb8_cmd_t;

    // Cells are big-endian, so the first beat of a cell carries the hi byte.
    function automatic logic [DSZ-1:0] first_byte(input mb8_cmd_t c);
        return c.ws ? c.wd[CSZ-1:DSZ] : c.wd[DSZ-1:0];
    endfunction

endpackage

// File: rtl/mb8_arb_if.sv
// rtl/mb8_arb_if.sv - byte-wide single-port RAM bus between the arbiter and spram8_128k
interface mb8_io;
    import mb8_pkg::*;

    logic [ASZ-1:0] m_ai;
    logic [DSZ-1:0] m_vi;
    logic           m_we;
    logic [DSZ-1:0] m_vo;

    modport master (
        output m_ai,
        output m_vi,
        output m_we,
        input  m_vo
    );

    modport slave (
        input  m_ai,
        input  m_vi,
        input  m_we,
        output m_vo
    );

endinterface

// File: rtl/mb8_arb_rr2.sv
// rtl/mb8_arb_rr2.sv - two-way round-robin picker; on a tie the port that did not win last time is chosen
module mb8_rr2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/mb8_arb.sv
// rtl/mb8_arb.sv - two-port round-robin sequencer moving bytes or big-endian 16-bit cells
// through one 8-bit single-port RAM with registered read data.
module mb8_arb
    import mb8_pkg::*;
(
    input  logic           clk,
    input  logic           rst,

    input  logic           p0_req,
    input  logic           p0_we,
    input  logic           p0_ws,
    input  logic [ASZ-1:0] p0_ad,
    input  logic [CSZ-1:0] p0_wd,
    output logic           p0_ack,
    output logic [CSZ-1:0] p0_rd,

    input  logic           p1_req,
    input  logic           p1_we,
    input  logic           p1_ws,
    input  logic [ASZ-1:0] p1_ad,
    input  logic [CSZ-1:0] p1_wd,
    output logic           p1_ack,
    output logic [CSZ-1:0] p1_rd,

    mb8_io.master          ram
);

    arb_st_t        st;
    mb8_cmd_t       cmd;
    mb8_cmd_t       cmd_in;
    logic           last_q;
    logic           gsel_q;
    logic [DSZ-1:0] hi_q;
    logic [1:0]     gnt;
    logic [ASZ-1:0] ad_nx;
    logic [CSZ-1:0] rd_asm;

    logic [ASZ-1:0] m_ai_q;
    logic [DSZ-1:0] m_vi_q;
    logic           m_we_q;

    mb8_rr2 u_rr (
        .req  ({p1_req, p0_req}),
        .last (last_q),
        .gnt  (gnt)
    );

    always_comb begin
        if (gnt[1]) begin
            cmd_in = '{we: p1_we, ws: p1_ws, ad: p1_ad, wd: p1_wd};
        end else begin
            cmd_in = '{we: p0_we, ws: p0_ws, ad: p0_ad, wd: p0_wd};
        end
    end

    // Address arithmetic stays ASZ bits wide so the lo byte of a cell at the top wraps to 0.
    assign ad_nx  = cmd.ad + ASZ'(1);
    assign rd_asm = cmd.ws ? {hi_q, ram.m_vo} : {{DSZ{1'b0}}, ram.m_vo};

    assign ram.m_ai = m_ai_q;
    assign ram.m_vi = m_vi_q;
    assign ram.m_we = m_we_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st     <= IDLE;
            cmd    <= '0;
            last_q <= 1'b1;
            gsel_q <= 1'b0;
            hi_q   <= '0;
            m_ai_q <= '0;
            m_vi_q <= '0;
            m_we_q <= 1'b0;
            p0_ack <= 1'b0;
            p1_ack <= 1'b0;
            p0_rd  <= '0;
            p1_rd  <= '0;
        end else begin
            p0_ack <= 1'b0;
            p1_ack <= 1'b0;
            case (st)
                IDLE: begin
                    if (|gnt) begin
                        cmd    <= cmd_in;
                        last_q <= gnt[1];
                        gsel_q <= gnt[1];
                        m_ai_q <= cmd_in.ad;
                        m_vi_q <= first_byte(cmd_in);
                        m_we_q <= cmd_in.we;
                        st     <= B0;
                    end else begin
                        m_we_q <= 1'b0;
                    end
                end
                B0: begin
                    if (cmd.ws) begin
                        m_ai_q <= ad_nx;
                        m_vi_q <= cmd.wd[DSZ-1:0];
                        m_we_q <= cmd.we;
                        st     <= B1;
                    end else begin
                        m_we_q <= 1'b0;
                        st     <= ACK;
                    end
                end
                B1: begin
                    // RAM now presents the byte addressed during B0.
                    hi_q   <= ram.m_vo;
                    m_we_q <= 1'b0;
                    st     <= ACK;
                end
                ACK: begin
                    if (gsel_q) begin
                        p1_ack <= 1'b1;
                        p1_rd  <= rd_asm;
                    end else begin
                        p0_ack <= 1'b1;
                        p0_rd  <= rd_asm;
                    end
                    m_we_q <= 1'b0;
                    st     <= IDLE;
                end
                default: begin
                    m_we_q <= 1'b0;
                    st     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mb8_arb.sv
// tb/tb_mb8_arb.sv - directed and randomized bench for mb8_arb with a transaction-level RAM model
`timescale 1ns/1ps
module tb_mb8_arb;
    import mb8_pkg::*;

    localparam int MSZ = 1 << ASZ;

    typedef struct {
        bit          we;
        bit          ws;
        int unsigned ad;
        int unsigned wd;
    } tcmd_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic           req [2];
    logic           we  [2];
    logic           ws  [2];
    logic [ASZ-1:0] ad  [2];
    logic [CSZ-1:0] wd  [2];
    logic           p0_ack, p1_ack;
    logic [CSZ-1:0] p0_rd, p1_rd;

    mb8_io bus ();

    mb8_arb dut (
        .clk    (clk),
        .rst    (rst),
        .p0_req (req[0]),
        .p0_we  (we[0]),
        .p0_ws  (ws[0]),
        .p0_ad  (ad[0]),
        .p0_wd  (wd[0]),
        .p0_ack (p0_ack),
        .p0_rd  (p0_rd),
        .p1_req (req[1]),
        .p1_we  (we[1]),
        .p1_ws  (ws[1]),
        .p1_ad  (ad[1]),
        .p1_wd  (wd[1]),
        .p1_ack (p1_ack),
        .p1_rd  (p1_rd),
        .ram    (bus)
    );

    int tests = 0;
    int fails = 0;

    // Behavioural RAM: registered read of the address presented before the edge.
    logic [7:0] ram [MSZ];
    initial begin
        for (int i = 0; i < MSZ; i++) ram[i] = 8'h00;
        forever begin
            @(posedge clk);
            bus.m_vo <= ram[bus.m_ai];
            if (bus.m_we) ram[bus.m_ai] = bus.m_vi;
        end
    end

    // Transaction model: serves one request at a time, beats at grant+1 and grant+2,
    // completion strobe after the last beat, ties go to the port that did not go last.
    logic [7:0]  shadow [MSZ];
    bit          exp_ack [2];
    bit          granted [2];
    bit          exp_rdv;
    logic [15:0] exp_rd;
    int          cyc;
    initial begin
        bit          mbusy;
        bit          mlast;
        int          mel, mtot, mport, p;
        int unsigned a;
        tcmd_t       mc;
        logic [7:0]  b0, b1;
        for (int i = 0; i < MSZ; i++) shadow[i] = 8'h00;
        mbusy = 0; mlast = 1; cyc = 0; mel = 0; mtot = 0; mport = 0; b0 = 0; b1 = 0;
        exp_rdv = 0; exp_rd = 0;
        exp_ack[0] = 0; exp_ack[1] = 0; granted[0] = 0; granted[1] = 0;
        forever begin
            @(posedge clk);
            cyc++;
            exp_ack[0] = 0;
            exp_ack[1] = 0;
            if (rst) begin
                mbusy = 0; mlast = 1; granted[0] = 0; granted[1] = 0;
            end else if (mbusy) begin
                mel++;
                a = (mc.ad + ((mel == 2) ? 1 : 0)) % MSZ;
                if (mel == 1) begin
                    b0 = shadow[a];
                    if (mc.we) shadow[a] = mc.ws ? 8'(mc.wd >> 8) : 8'(mc.wd);
                end else if (mel == 2 && mc.ws) begin
                    b1 = shadow[a];
                    if (mc.we) shadow[a] = 8'(mc.wd);
                end
                if (mel == mtot) begin
                    exp_ack[mport] = 1;
                    exp_rdv = !mc.we;
                    exp_rd  = mc.ws ? {b0, b1} : {8'h00, b0};
                    mbusy = 0;
                    granted[mport] = 0;
                end
            end else begin
                p = -1;
                if (req[0] && req[1]) p = mlast ? 0 : 1;
                else if (req[0])      p = 0;
                else if (req[1])      p = 1;
                if (p >= 0) begin
                    mport = p;
                    mc.we = we[p]; mc.ws = ws[p]; mc.ad = ad[p]; mc.wd = wd[p];
                    mtot  = mc.ws ? 3 : 2;
                    mel   = 0;
                    mbusy = 1;
                    mlast = (p == 1);
                    granted[p] = 1;
                end
            end
        end
    end

    tcmd_t       q0 [$];
    tcmd_t       q1 [$];
    bit          active [2] = '{0, 0};
    int          raise_cyc [2] = '{0, 0};
    bit          scramble = 0;
    int          lg_port [$];
    logic [15:0] lg_rd [$];
    int          lg_cyc [$];

    task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic cmp_step();
        if (!rst) begin
            chk("p0_ack", 32'(p0_ack), 32'(exp_ack[0]));
            chk("p1_ack", 32'(p1_ack), 32'(exp_ack[1]));
            if (exp_ack[0] && exp_rdv) chk("p0_rd", 32'(p0_rd), 32'(exp_rd));
            if (exp_ack[1] && exp_rdv) chk("p1_rd", 32'(p1_rd), 32'(exp_rd));
            if (p0_ack) begin lg_port.push_back(0); lg_rd.push_back(p0_rd); lg_cyc.push_back(cyc); end
            if (p1_ack) begin lg_port.push_back(1); lg_rd.push_back(p1_rd); lg_cyc.push_back(cyc); end
        end
    endtask

    task automatic drv_step();
        tcmd_t c;
        bit    got;
        for (int p = 0; p < 2; p++) begin
            if (rst) begin
                req[p] = 0; we[p] = 0; ws[p] = 0; ad[p] = '0; wd[p] = '0; active[p] = 0;
            end else begin
                if (active[p] && ((p == 0) ? p0_ack : p1_ack)) active[p] = 0;
                got = 0;
                if (!active[p]) begin
                    if (p == 0 && q0.size() != 0) begin c = q0.pop_front(); got = 1; end
                    if (p == 1 && q1.size() != 0) begin c = q1.pop_front(); got = 1; end
                end
                if (got) begin
                    req[p] = 1; we[p] = c.we; ws[p] = c.ws;
                    ad[p] = ASZ'(c.ad); wd[p] = CSZ'(c.wd);
                    active[p] = 1; raise_cyc[p] = cyc;
                end else if (!active[p]) begin
                    req[p] = 0;
                end else if (scramble && granted[p]) begin
                    ad[p] = ASZ'($urandom); wd[p] = CSZ'($urandom);
                    we[p] = 1'($urandom);   ws[p] = 1'($urandom);
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cmp_step();
        drv_step();
    endtask

    task automatic push(input int p, input bit w, input bit s, input int unsigned a, input int unsigned d);
        tcmd_t c;
        c.we = w; c.ws = s; c.ad = a; c.wd = d;
        if (p == 0) q0.push_back(c); else q1.push_back(c);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || active[0] || active[1]) && n < 4000) begin
            tick();
            n++;
        end
        if (n >= 4000) begin
            tests++; fails++;
            $display("FAIL timeout: requests still pending after %0d cycles", n);
        end
        tick();
    endtask

    function automatic int unsigned last_rd();
        if (lg_rd.size() == 0) return 32'hDEAD;
        return 32'(lg_rd[lg_rd.size()-1]);
    endfunction

    function automatic int unsigned last_port();
        if (lg_port.size() == 0) return 32'hDEAD;
        return 32'(lg_port[lg_port.size()-1]);
    endfunction

    function automatic int unsigned last_lat(input int p);
        if (lg_cyc.size() == 0) return 32'hDEAD;
        return 32'(lg_cyc[lg_cyc.size()-1] - raise_cyc[p] - 1);
    endfunction

    function automatic int unsigned pick_ad();
        int unsigned r;
        r = $urandom_range(0, 47);
        if (r < 16) return r;
        if (r < 32) return 32'h1000 + r - 16;
        return 32'h1FFF0 + r - 32;
    endfunction

    initial begin
        int          n0;
        int unsigned order, mism;
        repeat (3) tick();
        chk("reset p0_ack", 32'(p0_ack), 0);
        chk("reset p1_ack", 32'(p1_ack), 0);
        chk("reset p0_rd",  32'(p0_rd),  0);
        chk("reset p1_rd",  32'(p1_rd),  0);
        chk("reset m_we",   32'(bus.m_we), 0);
        chk("reset m_ai",   32'(bus.m_ai), 0);
        chk("reset m_vi",   32'(bus.m_vi), 0);
        rst = 0;
        tick();

        push(0, 1, 0, 'h00012, 'h00A5); wait_idle();
        push(0, 0, 0, 'h00012, 'h0000); wait_idle();
        chk("t1 byte read data", last_rd(), 'h00A5);
        chk("t1 ack port", last_port(), 0);
        chk("t1 byte latency", last_lat(0), 2);

        push(1, 1, 1, 'h01000, 'hBEEF); wait_idle();
        push(1, 0, 0, 'h01000, 'h0000); wait_idle();
        chk("t2 hi byte read", last_rd(), 'h00BE);
        push(1, 0, 0, 'h01001, 'h0000); wait_idle();
        chk("t2 lo byte read", last_rd(), 'h00EF);
        push(1, 0, 1, 'h01000, 'h0000); wait_idle();
        chk("t2 cell read", last_rd(), 'hBEEF);
        chk("t2 cell latency", last_lat(1), 3);
        chk("t2 ack port", last_port(), 1);

        push(0, 1, 1, 'h1FFFF, 'h1234); wait_idle();
        chk("t3 ram 1FFFF", 32'(ram['h1FFFF]), 'h12);
        chk("t3 ram 00000", 32'(ram[0]), 'h34);
        push(0, 0, 1, 'h1FFFF, 'h0000); wait_idle();
        chk("t3 wrapped cell read", last_rd(), 'h1234);

        rst = 1; tick(); tick(); rst = 0; tick();
        for (int i = 0; i < 3; i++) begin
            push(0, 1, 0, 'h300 + 2 * i, 'h40 + i);
            push(1, 1, 0, 'h301 + 2 * i, 'h80 + i);
        end
        n0 = lg_port.size();
        wait_idle();
        order = 0;
        for (int k = 0; k < 6; k++)
            if (n0 + k < lg_port.size()) order |= (32'(lg_port[n0 + k]) << k);
            else order |= 32'h100;
        chk("t4 grant order", order, 'h2A);
        chk("t4 ram 0305", 32'(ram['h305]), 'h82);

        push(0, 1, 1, 'h00200, 'hCAFE);
        tick(); tick(); tick();
        chk("t5 m_we in B1", 32'(bus.m_we), 1);
        rst = 1;
        #1;
        chk("t5 m_we async drop", 32'(bus.m_we), 0);
        tick();
        tick();
        rst = 0;
        repeat (4) tick();
        chk("t5 no ack after reset", 32'(p0_ack | p1_ack), 0);
        chk("t5 ram 0200", 32'(ram['h200]), 'hCA);
        chk("t5 ram 0201", 32'(ram['h201]), 'h00);
        push(0, 0, 1, 'h00200, 'h0000); wait_idle();
        chk("t5 recovery read", last_rd(), 'hCA00);

        scramble = 1;
        push(1, 1, 1, 'h01005, 'h7788);
        push(1, 0, 1, 'h01005, 'h0000);
        wait_idle();
        chk("t6 latched cell", last_rd(), 'h7788);
        for (int i = 0; i < 256; i++)
            push($urandom_range(0, 1), 1'($urandom), 1'($urandom), pick_ad(), $urandom_range(0, 'hFFFF));
        wait_idle();
        mism = 0;
        for (int i = 0; i < MSZ; i++) if (ram[i] !== shadow[i]) mism++;
        chk("t6 ram image vs model", mism, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
